// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if: request/readback bundle for the AES key-schedule block.
// The zeroize request only exists when AES_KEY_SCHED_ZEROIZE_EN is defined.
interface aes_key_sched_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rd_round;
    logic [127:0] rk_out;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   rk_avail;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    modport master (output start, key_len, key_in, rd_round, zeroize,
                    input  rk_out, busy, done, err, rk_avail);
    modport slave  (input  start, key_len, key_in, rd_round, zeroize,
                    output rk_out, busy, done, err, rk_avail);
`else
    modport master (output start, key_len, key_in, rd_round,
                    input  rk_out, busy, done, err, rk_avail);
    modport slave  (input  start, key_len, key_in, rd_round,
                    output rk_out, busy, done, err, rk_avail);
`endif
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128/192/256 key expansion, one word per cycle,
// with round keys readable as soon as each group of four words lands.
// Optional feature macro: AES_KEY_SCHED_ZEROIZE_EN (buffer wipe on request).

// Combinational AES S-box: GF(2^8) inverse as a^254, then the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Square-and-multiply chain gives a^(2+4+...+128) = a^254 (0 maps to 0).
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_sched #(
    parameter int MAX_KEY_W = 256
) (
    input logic            clk,
    input logic            rst_n,
    aes_key_sched_if.slave bus
);
    localparam int MAX_NK = MAX_KEY_W / 32;
    localparam int MAX_NR = MAX_NK + 6;
    localparam int WORDS  = 4 * (MAX_NR + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, ZERO} state_t;

    state_t      state, state_nxt;
    logic [1:0]  klen;
    logic [3:0]  nk, nr;
    logic [3:0]  nk_dec;
    logic [5:0]  widx;
    logic [2:0]  kcnt;
    logic [7:0]  rcon;
    logic [3:0]  rk_avail;
    logic        err;
    logic        legal;
    logic [5:0]  last_idx;
    logic [31:0] prev, back, sub, temp, new_word;
    logic [31:0] wbuf [WORDS];

    // Last word index is 4*(Nr+1)-1 = 4*Nr+3.
    assign last_idx = {nr, 2'b11};

    // Key length is legal if encoded and not wider than this build supports.
    always_comb begin
        legal = 1'b0;
        case (bus.key_len)
            2'b00:   legal = 1'b1;
            2'b01:   legal = (MAX_KEY_W >= 192);
            2'b10:   legal = (MAX_KEY_W >= 256);
            default: legal = 1'b0;
        endcase
    end

    // Nk decode from the key length latched at the accepted start.
    always_comb begin
        nk_dec = 4'd4;
        case (klen)
            2'b01:   nk_dec = 4'd6;
            2'b10:   nk_dec = 4'd8;
            default: nk_dec = 4'd4;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; starts win over zeroize when both arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && legal) state_nxt = LOAD;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
                else if (!bus.start && bus.zeroize) state_nxt = ZERO;
`endif
            end
            LOAD:   state_nxt = EXPAND;
            EXPAND: if (widx == last_idx) state_nxt = IDLE;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
            ZERO:   if (widx == 6'(WORDS - 1)) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Four shared S-boxes act on w[i-1]; RotWord commutes with SubWord,
    // so the rotation is applied after substitution.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(prev[8*g +: 8]), .s(sub[8*g +: 8]));
    end

    // Word recurrence: w[i] = w[i-Nk] ^ f(w[i-1]); kcnt tracks i mod Nk.
    always_comb begin
        prev = wbuf[widx - 6'd1];
        back = wbuf[widx - {2'b00, nk}];
        temp = prev;
        if (kcnt == 3'd0)
            temp = {sub[23:0], sub[31:24]} ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && kcnt == 3'd4)
            temp = sub;
        new_word = back ^ temp;
    end

    // Control/datapath registers: indices, Rcon, availability count, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klen     <= 2'b00;
            nk       <= 4'd4;
            nr       <= 4'd10;
            widx     <= 6'd0;
            kcnt     <= 3'd0;
            rcon     <= 8'h01;
            rk_avail <= 4'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (legal) begin
                            klen     <= bus.key_len;
                            err      <= 1'b0;
                            rk_avail <= 4'd0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
`ifdef AES_KEY_SCHED_ZEROIZE_EN
                    else if (bus.zeroize) begin
                        widx     <= 6'd0;
                        rk_avail <= 4'd0;
                    end
`endif
                end
                LOAD: begin
                    nk       <= nk_dec;
                    nr       <= nk_dec + 4'd6;
                    widx     <= {2'b00, nk_dec};
                    kcnt     <= 3'd0;
                    rcon     <= 8'h01;
                    rk_avail <= nk_dec >> 2;
                end
                EXPAND: begin
                    widx <= widx + 6'd1;
                    kcnt <= ({1'b0, kcnt} == nk - 4'd1) ? 3'd0 : kcnt + 3'd1;
                    if (kcnt == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (widx[1:0] == 2'b11 && rk_avail <= nr)
                        rk_avail <= rk_avail + 4'd1;
                end
`ifdef AES_KEY_SCHED_ZEROIZE_EN
                ZERO: widx <= widx + 6'd1;
`endif
                default: ;
            endcase
        end
    end

    // Word buffer; deliberately not reset, rk_avail gates every read.
    always_ff @(posedge clk) begin
        case (state)
            LOAD: begin
                for (int k = 0; k < 8; k++)
                    if (k < int'(nk_dec)) wbuf[k] <= bus.key_in[255 - 32*k -: 32];
            end
            EXPAND: wbuf[widx] <= new_word;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
            ZERO:   wbuf[widx] <= 32'h0;
`endif
            default: ;
        endcase
    end

    // Round-key readback: only complete, current keys are visible.
    always_comb begin
        bus.rk_out = '0;
        if (bus.rd_round < rk_avail)
            bus.rk_out = {wbuf[{bus.rd_round, 2'b00}], wbuf[{bus.rd_round, 2'b01}],
                          wbuf[{bus.rd_round, 2'b10}], wbuf[{bus.rd_round, 2'b11}]};
    end

    assign bus.busy     = (state != IDLE);
    assign bus.err      = err;
    assign bus.rk_avail = rk_avail;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign bus.done = (state == EXPAND && widx == last_idx) ||
                      (state == ZERO && widx == 6'(WORDS - 1));
`else
    assign bus.done = (state == EXPAND && widx == last_idx);
`endif
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: known-answer table, hand-written corner sequences and
// randomized keys checked against a FIPS-197 reference model.
module tb_aes_key_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_sched_if b ();
    aes_key_sched_if b2 ();

    aes_key_sched #(.MAX_KEY_W(256)) dut  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    aes_key_sched #(.MAX_KEY_W(128)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [3:0]   rd;
        logic [127:0] rk;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference GF(2^8) product, plain integer arithmetic.
    function automatic int gm(input int x, input int y);
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((y >> i) & 1) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11b;
        end
        return p;
    endfunction

    // S-box table: inverse found by search, affine transform bit by bit.
    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(x, y) == 1) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [7:0] rc(input int j);
        int r = 1;
        for (int k = 1; k < j; k++) begin
            r = r << 1;
            if (r > 255) r = r ^ 'h11b;
        end
        return 8'(r);
    endfunction

    task automatic model(input logic [1:0] kl, input logic [255:0] key);
        int nk, nr;
        logic [31:0] t;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = subw(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // Full expansion on dut; 'poke' > 0 fires an illegal start in that busy cycle.
    task automatic expand(input logic [1:0] kl, input logic [255:0] key, input int poke, input string tag);
        int nk, nr, c, dc, av;
        bit tr;
        nk = 4 + 2 * int'(kl);
        nr = nk + 6;
        @(negedge clk);
        b.start = 1'b1; b.key_len = kl; b.key_in = key;
        @(negedge clk);
        b.start = 1'b0;
        c = 1; dc = -1; tr = 1'b1;
        while (c < 120) begin
            av = (c < 2) ? 0 : (nk + c - 2) / 4;
            if (av > nr + 1) av = nr + 1;
            if (b.rk_avail !== 4'(av) || b.busy !== 1'b1 || b.err !== 1'b0) tr = 1'b0;
            if (b.done === 1'b1) begin dc = c; break; end
            if (c == poke) begin b.start = 1'b1; b.key_len = 2'b11; end
            @(negedge clk);
            b.start = 1'b0; b.key_len = kl;
            c++;
        end
        chk({tag, " done_cycle"}, 256'(dc), 256'(41 + 6 * int'(kl)));
        chk({tag, " avail_trace"}, 256'(tr), 256'd1);
        @(negedge clk);
        chk({tag, " idle_after"}, {b.busy, b.done, b.err, b.rk_avail}, {3'b000, 4'(nr + 1)});
    endtask

    task automatic chk_rounds(input logic [1:0] kl, input logic [255:0] key, input string tag);
        int nr;
        logic [127:0] e;
        nr = 10 + 2 * int'(kl);
        model(kl, key);
        for (int r = 0; r < 16; r++) begin
            b.rd_round = 4'(r);
            #1;
            e = (r <= nr) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0;
            chk($sformatf("%s rk%0d", tag, r), b.rk_out, e);
        end
    endtask

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int c, kl;
        logic [255:0] key;
        b.start = 0; b.key_len = 0; b.key_in = '0; b.rd_round = 0;
        b2.start = 0; b2.key_len = 0; b2.key_in = '0; b2.rd_round = 0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        b.zeroize = 1'b0; b2.zeroize = 1'b0;
`endif
        build_sbox();
        tbl[0] = '{2'b00, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[1] = '{2'b00, K128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[2] = '{2'b00, K128, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3] = '{2'b00, K128, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        tbl[4] = '{2'b01, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        tbl[5] = '{2'b01, K192, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        tbl[6] = '{2'b10, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        tbl[7] = '{2'b10, K256, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        tbl[8] = '{2'b10, K256, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};

        // Reset state.
        #2;
        chk("reset_state", {b.busy, b.done, b.err, b.rk_avail, b.rk_out}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors.
        for (int i = 0; i < 9; i++) begin
            expand(tbl[i].kl, tbl[i].key, 0, $sformatf("kat%0d", i));
            b.rd_round = tbl[i].rd;
            #1;
            chk($sformatf("kat%0d rk", i), b.rk_out, tbl[i].rk);
        end

        // Read behind expansion: round 2 valid, round 3 zero when avail first hits 3.
        @(negedge clk);
        b.start = 1'b1; b.key_len = 2'b00; b.key_in = K128;
        @(negedge clk);
        b.start = 1'b0;
        c = 0;
        while (b.rk_avail !== 4'd3 && c < 100) begin @(negedge clk); c++; end
        chk("pipe_wait", 256'(c < 100), 256'd1);
        b.rd_round = 4'd2; #1;
        chk("pipe_rk2", b.rk_out, 128'hf2c295f27a96b9435935807a7359f67f);
        b.rd_round = 4'd3; #1;
        chk("pipe_rk3_zero", b.rk_out, 128'h0);
        c = 0;
        while (b.busy !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        chk("pipe_finish", 256'(c < 100), 256'd1);

        // Start while busy is ignored (illegal key_len also must not set err).
        expand(2'b00, K128, 12, "busy_poke");
        b.rd_round = 4'd10; #1;
        chk("busy_poke rk10", b.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Illegal key_len: err set, nothing else changes; next legal start clears it.
        @(negedge clk);
        b.start = 1'b1; b.key_len = 2'b11; b.key_in = K256;
        @(negedge clk);
        b.start = 1'b0;
        chk("illegal_flags", {b.err, b.busy, b.rk_avail}, {2'b10, 4'd11});
        b.rd_round = 4'd10; #1;
        chk("illegal_keep_rk", b.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        b.start = 1'b1; b.key_len = 2'b01; b.key_in = K192;
        @(negedge clk);
        b.start = 1'b0;
        chk("legal_clears_err", {b.err, b.busy, b.rk_avail}, {2'b01, 4'd0});
        c = 0;
        while (b.busy !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        chk("legal_finish", 256'(c < 100), 256'd1);
        chk_rounds(2'b01, K192, "after_err");

        // 128-bit build rejects AES-256.
        @(negedge clk);
        b2.start = 1'b1; b2.key_len = 2'b00; b2.key_in = K128;
        @(negedge clk);
        b2.start = 1'b0;
        c = 0;
        while (b2.busy !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        chk("m128_first", {b2.err, b2.rk_avail}, {1'b0, 4'd11});
        b2.start = 1'b1; b2.key_len = 2'b10; b2.key_in = K256;
        @(negedge clk);
        b2.start = 1'b0;
        chk("m128_reject", {b2.err, b2.busy, b2.rk_avail}, {2'b10, 4'd11});
        b2.rd_round = 4'd10; #1;
        chk("m128_keep_rk", b2.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(negedge clk);
        b2.start = 1'b1; b2.key_len = 2'b00; b2.key_in = K128;
        @(negedge clk);
        b2.start = 1'b0;
        chk("m128_clear", {b2.err, b2.busy}, 2'b01);
        c = 0;
        while (b2.busy !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        chk("m128_finish", 256'(c < 100), 256'd1);

        // Randomized keys against the reference model.
        for (int n = 0; n < 20; n++) begin
            kl = $urandom_range(0, 2);
            for (int w = 0; w < 8; w++) key[32*w +: 32] = $urandom;
            expand(2'(kl), key, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0,
                   $sformatf("rnd%0d", n));
            chk_rounds(2'(kl), key, $sformatf("rnd%0d", n));
        end

        // Asynchronous reset mid-expansion, then a clean restart.
        @(negedge clk);
        b.start = 1'b1; b.key_len = 2'b10; b.key_in = K256;
        @(negedge clk);
        b.start = 1'b0;
        for (int k = 1; k < 20; k++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {b.busy, b.done, b.err, b.rk_avail}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 8; w++) key[32*w +: 32] = $urandom;
        expand(2'b10, key, 0, "post_reset");
        chk_rounds(2'b10, key, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
